// File: rtl/mem_sequencer_if.sv
// Decoder <-> memory-unit sequencer bundle.
// master: decoder side (drives start/op/halt, observes handshake and strobes).
// slave : sequencer side (consumes request, drives handshake and strobes).
//   start, op[2:0], halt            request / flow control
//   ready, busy, done, dst_we       handshake and completion
//   ctrl_*                          registered memory-unit strobes
interface mem_sequencer_if;
    logic       start;
    logic [2:0] op;
    logic       halt;
    logic       ready;
    logic       busy;
    logic       done;
    logic       dst_we;
    logic       ctrl_pc_load_n;
    logic       ctrl_pc_n_en;
    logic       ctrl_pc_from_imm;
    logic       ctrl_mem_pc_to_ram_n;
    logic       ctrl_sp_up;
    logic       ctrl_sp_n_en;
    logic       ctrl_instr_n_we;
    logic       ctrl_ram_n_oe;
    logic       ctrl_ram_n_we;
    logic       ctrl_mem_mar0_n_we;
    logic       ctrl_mem_mar1_n_we;
    logic       ctrl_mem_instr_imm_to_ram_addr;

    modport master (
        output start, op, halt,
        input  ready, busy, done, dst_we,
        input  ctrl_pc_load_n, ctrl_pc_n_en, ctrl_pc_from_imm, ctrl_mem_pc_to_ram_n,
        input  ctrl_sp_up, ctrl_sp_n_en, ctrl_instr_n_we, ctrl_ram_n_oe, ctrl_ram_n_we,
        input  ctrl_mem_mar0_n_we, ctrl_mem_mar1_n_we, ctrl_mem_instr_imm_to_ram_addr
    );

    modport slave (
        input  start, op, halt,
        output ready, busy, done, dst_we,
        output ctrl_pc_load_n, ctrl_pc_n_en, ctrl_pc_from_imm, ctrl_mem_pc_to_ram_n,
        output ctrl_sp_up, ctrl_sp_n_en, ctrl_instr_n_we, ctrl_ram_n_oe, ctrl_ram_n_we,
        output ctrl_mem_mar0_n_we, ctrl_mem_mar1_n_we, ctrl_mem_instr_imm_to_ram_addr
    );
endinterface

// File: rtl/mem_sequencer.sv
// Memory-unit micro-sequencer. Accepts one op per start/ready handshake and
// expands it into one or two timed strobe steps; RAM steps are stretched by
// RAM_WAIT extra cycles. All strobes come straight from flops.
//   i_clk, i_reset : clock, synchronous active-high reset
//   bus (slave)    : request, handshake and memory-unit strobes
module mem_sequencer #(
    parameter int RAM_WAIT = 1
) (
    input  logic           i_clk,
    input  logic           i_reset,
    mem_sequencer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, STEP1, STEP2} state_t;

    localparam logic [2:0] OP_FETCH = 3'd0, OP_LOAD = 3'd1, OP_STORE = 3'd2, OP_PUSH = 3'd3,
                           OP_POP   = 3'd4, OP_JUMP = 3'd5, OP_RET   = 3'd6, OP_SETMAR = 3'd7;
    localparam logic [3:0] WAIT4 = 4'(RAM_WAIT);

    typedef struct packed {
        logic busy, done, dst_we;
        logic pc_load_n, pc_n_en, pc_from_imm;
        logic sp_up, sp_n_en, instr_n_we;
        logic ram_n_oe, ram_n_we, mar0_n_we, mar1_n_we, imm_to_ram_addr;
    } strobe_t;

    localparam strobe_t STROBE_IDLE = '{busy: 1'b0, done: 1'b0, dst_we: 1'b0,
                                        pc_load_n: 1'b1, pc_n_en: 1'b1, pc_from_imm: 1'b0,
                                        sp_up: 1'b0, sp_n_en: 1'b1, instr_n_we: 1'b1,
                                        ram_n_oe: 1'b1, ram_n_we: 1'b1, mar0_n_we: 1'b1,
                                        mar1_n_we: 1'b1, imm_to_ram_addr: 1'b0};

    state_t     state, state_nx;
    logic [2:0] op_q, op_nx;
    logic [3:0] cnt, cnt_nx;     // remaining extra cycles of the current step
    strobe_t    strb, strb_nx;

    function automatic logic is_ram(input state_t s, input logic [2:0] op);
        case (op)
            OP_LOAD, OP_STORE, OP_PUSH: return s == STEP1;
            OP_POP, OP_RET:             return s == STEP2;
            default:                    return 1'b0;
        endcase
    endfunction

    function automatic logic two_step(input logic [2:0] op);
        return op == OP_PUSH || op == OP_POP || op == OP_RET || op == OP_SETMAR;
    endfunction

    assign bus.ready = (state == IDLE) && !bus.halt && !i_reset;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state <= IDLE;
            op_q  <= OP_FETCH;
            cnt   <= '0;
            strb  <= STROBE_IDLE;
        end else begin
            state <= state_nx;
            op_q  <= op_nx;
            cnt   <= cnt_nx;
            strb  <= strb_nx;
        end
    end

    always_comb begin
        state_nx = state;
        op_nx    = op_q;
        cnt_nx   = cnt;
        case (state)
            IDLE: if (bus.start && bus.ready) begin
                state_nx = STEP1;
                op_nx    = bus.op;
                cnt_nx   = is_ram(STEP1, bus.op) ? WAIT4 : 4'd0;
            end
            STEP1: if (cnt != 4'd0) begin
                cnt_nx = cnt - 4'd1;
            end else if (two_step(op_q)) begin
                state_nx = STEP2;
                cnt_nx   = is_ram(STEP2, op_q) ? WAIT4 : 4'd0;
            end else begin
                state_nx = IDLE;
            end
            STEP2: if (cnt != 4'd0) cnt_nx = cnt - 4'd1;
                   else             state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Strobes for the cycle about to start, decoded from the next state so
    // they can be registered. "last" marks the final cycle of a step, where
    // every state-changing enable lives.
    always_comb begin
        logic last;
        strb_nx = STROBE_IDLE;
        last    = (cnt_nx == 4'd0);
        if (state_nx != IDLE) begin
            strb_nx.busy = 1'b1;
            strb_nx.done = last && (state_nx == STEP2 || !two_step(op_nx));
            case (op_nx)
                OP_FETCH: begin
                    strb_nx.instr_n_we = 1'b0;
                    strb_nx.pc_n_en    = 1'b0;
                end
                OP_LOAD: begin
                    strb_nx.ram_n_oe        = 1'b0;
                    strb_nx.imm_to_ram_addr = 1'b1;
                    strb_nx.dst_we          = last;
                end
                OP_STORE: strb_nx.ram_n_we = 1'b0;
                OP_PUSH: if (state_nx == STEP1) begin
                    strb_nx.ram_n_we        = 1'b0;
                    strb_nx.imm_to_ram_addr = 1'b1;
                end else begin
                    strb_nx.sp_n_en = 1'b0;
                    strb_nx.sp_up   = 1'b1;
                end
                OP_POP: if (state_nx == STEP1) begin
                    strb_nx.sp_n_en = 1'b0;
                end else begin
                    strb_nx.ram_n_oe        = 1'b0;
                    strb_nx.imm_to_ram_addr = 1'b1;
                    strb_nx.dst_we          = last;
                end
                OP_JUMP: begin
                    strb_nx.pc_n_en     = 1'b0;
                    strb_nx.pc_load_n   = 1'b0;
                    strb_nx.pc_from_imm = 1'b1;
                end
                OP_RET: if (state_nx == STEP1) begin
                    strb_nx.sp_n_en = 1'b0;
                end else begin
                    // return address is read from the stack, then loaded into PC
                    strb_nx.ram_n_oe        = 1'b0;
                    strb_nx.imm_to_ram_addr = 1'b1;
                    strb_nx.pc_n_en         = !last;
                    strb_nx.pc_load_n       = !last;
                end
                OP_SETMAR: if (state_nx == STEP1) strb_nx.mar0_n_we = 1'b0;
                           else                   strb_nx.mar1_n_we = 1'b0;
                default: ;
            endcase
        end
    end

    assign bus.busy                           = strb.busy;
    assign bus.done                           = strb.done;
    assign bus.dst_we                         = strb.dst_we;
    assign bus.ctrl_pc_load_n                 = strb.pc_load_n;
    assign bus.ctrl_pc_n_en                   = strb.pc_n_en;
    assign bus.ctrl_pc_from_imm               = strb.pc_from_imm;
    assign bus.ctrl_mem_pc_to_ram_n           = 1'b1;
    assign bus.ctrl_sp_up                     = strb.sp_up;
    assign bus.ctrl_sp_n_en                   = strb.sp_n_en;
    assign bus.ctrl_instr_n_we                = strb.instr_n_we;
    assign bus.ctrl_ram_n_oe                  = strb.ram_n_oe;
    assign bus.ctrl_ram_n_we                  = strb.ram_n_we;
    assign bus.ctrl_mem_mar0_n_we             = strb.mar0_n_we;
    assign bus.ctrl_mem_mar1_n_we             = strb.mar1_n_we;
    assign bus.ctrl_mem_instr_imm_to_ram_addr = strb.imm_to_ram_addr;
endmodule
